// File: rtl/mio_pkg.sv
// mio_pkg: shared size encodings, FSM states and alignment helper for the MIO bus master
package mio_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    // true when the low address bits are not a multiple of the access size
    function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size);
        return (addr & ((3'd1 << size) - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/mio_lane_align.sv
// mio_lane_align: byte enables, store replication and load extraction/extension
module mio_lane_align #(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int LW     = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        w_size,
    input  logic [LW-1:0]     w_lane,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        r_size,
    input  logic [LW-1:0]     r_lane,
    input  logic              r_sign,
    input  logic [DATA_W-1:0] data_in,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wrep,
    output logic [DATA_W-1:0] rext
);
    import mio_pkg::*;

    logic [7:0]        mask;
    logic [DATA_W-1:0] sh;
    logic              msb;

    // enable mask shifted to the lane, low bytes of store data repeated across the bus
    always_comb begin
        mask = w_size == SZ_BYTE ? 8'h01 : w_size == SZ_HALF ? 8'h03 : w_size == SZ_WORD ? 8'h0f : 8'hff;
        be = NB'({8'h00, mask} << w_lane);
        wrep = '0;
        for (int i = 0; i < NB; i++)
            wrep[8*i +: 8] = w_size == SZ_BYTE ? wdata[7:0] :
                             w_size == SZ_HALF ? wdata[8*(i%2) +: 8] :
                             w_size == SZ_WORD ? wdata[8*(i%4) +: 8] : wdata[8*(i%8) +: 8];
    end

    // right-justify the addressed lanes and fill the upper bits with sign or zero
    always_comb begin
        sh = data_in >> {r_lane, 3'b000};
        msb = r_sign & (r_size == SZ_BYTE ? sh[7] : r_size == SZ_HALF ? sh[15] :
                        r_size == SZ_WORD ? sh[31] : sh[DATA_W-1]);
        rext = '0;
        for (int b = 0; b < DATA_W; b++)
            rext[b] = (b < (8 << r_size)) ? sh[b] : msb;
    end

endmodule

// File: rtl/mio_bus_master.sv
// mio_bus_master: registered handshake access engine between the CPU FSM and the MIO bus
module mio_bus_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sign,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                cpu_mio,
    output logic                mem_w,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mio_ready,
    input  logic [DATA_W-1:0]   data_in
);
    import mio_pkg::*;

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic              we_r, sign_r, err_r, bad, at_limit;
    logic [1:0]        size_r;
    logic [LW-1:0]     lane_r;
    logic [NB-1:0]     be_w;
    logic [DATA_W-1:0] wrep, rext;

    assign bad = (req_size == SZ_DWORD && DATA_W == 32) || misaligned(req_addr[2:0], req_size);
    assign at_limit = cnt == CW'(TIMEOUT);

    mio_lane_align #(.DATA_W(DATA_W)) u_align (
        .w_size  (req_size),
        .w_lane  (req_addr[LW-1:0]),
        .wdata   (req_wdata),
        .r_size  (size_r),
        .r_lane  (lane_r),
        .r_sign  (sign_r),
        .data_in (data_in),
        .be      (be_w),
        .wrep    (wrep),
        .rext    (rext)
    );

    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    // next state: faults bypass the bus, ready beats the timeout on the limit cycle
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req_valid ? (bad ? FAULT : ACCESS) : IDLE;
            ACCESS:  next = (mio_ready || at_limit) ? DONE : ACCESS;
            default: next = IDLE;
        endcase
    end

    // outputs decoded from the registered state only
    always_comb begin
        busy    = state != IDLE;
        done    = state == DONE || state == FAULT;
        err     = state == FAULT || (state == DONE && err_r);
        cpu_mio = state == ACCESS;
        mem_w   = state == ACCESS && we_r;
    end

    // request capture, bus registers, wait counter and load data
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r     <= 1'b0;
            sign_r   <= 1'b0;
            size_r   <= SZ_BYTE;
            lane_r   <= '0;
            cnt      <= '0;
            err_r    <= 1'b0;
            rdata    <= '0;
            addr_out <= '0;
            data_out <= '0;
            mem_be   <= '0;
        end else if (state == IDLE && req_valid) begin
            we_r   <= req_we;
            sign_r <= req_sign;
            size_r <= req_size;
            lane_r <= req_addr[LW-1:0];
            cnt    <= '0;
            if (!bad) begin
                addr_out <= {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
                data_out <= wrep;
                mem_be   <= be_w;
            end
        end else if (state == ACCESS) begin
            if (mio_ready) begin
                err_r <= 1'b0;
                if (!we_r)
                    rdata <= rext;
            end else begin
                cnt   <= cnt + 1'b1;
                err_r <= at_limit;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_master.sv
// tb_mio_bus_master: scoreboard-driven checks of sizing, lanes, faults, timeout and reset
module tb_mio_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        busy, done, err, cpu_mio, mem_w;
    logic [31:0] rdata, addr_out, data_out;
    logic [3:0]  mem_be;
    logic        mio_ready = 1'b0;
    logic [31:0] data_in = '0;

    typedef struct {int lat; logic err; logic [31:0] rd;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic [31:0] last_rd = '0;

    int lat, nw, nc;
    logic [3:0] o_be;
    logic [31:0] o_ad, o_dout, o_rd;
    logic o_err;

    mio_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .cpu_mio(cpu_mio), .mem_w(mem_w), .addr_out(addr_out),
        .data_out(data_out), .mem_be(mem_be), .mio_ready(mio_ready), .data_in(data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] r = '0;
        for (int j = 0; j < (1 << sz); j++) r[(a % 4) + j] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] v = '0;
        int n = 1 << sz;
        for (int j = 0; j < n; j++) v[8*j +: 8] = d[8*((a % 4) + j) +: 8];
        if (sg && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    // drive one request, serve ready after wait_n access cycles, observe until done
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] din, input int wait_n);
        int idx = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nw = 0; nc = 0; o_be = 'x; o_ad = 'x; o_dout = 'x;
        while (!done && lat < 40) begin
            if (cpu_mio) begin
                if (nc == 0) begin o_be = mem_be; o_ad = addr_out; o_dout = data_out; end
                nc++;
                nw += int'(mem_w);
            end
            mio_ready = cpu_mio && idx == wait_n;
            data_in = mio_ready ? din : $urandom;
            if (cpu_mio) idx++;
            @(posedge clk); #1;
            lat++;
        end
        mio_ready = 1'b0;
        o_err = err; o_rd = rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, err, cpu_mio, mem_w} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, err, cpu_mio, mem_w}); end
        checks++; if ({rdata, addr_out, data_out, mem_be} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h %h exp all zero", rdata, addr_out, data_out, mem_be); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load;
        q.push_back('{1, 1'b0, 32'hDEADBEEF});
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        e = q.pop_front(); last_rd = e.rd;
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL word_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL word_result got %b %h exp %b %h", o_err, o_rd, e.err, e.rd); end
        checks++; if (o_be !== 4'b1111 || o_ad !== 32'h100 || nw !== 0) begin errors++; $display("FAIL word_bus got be %b addr %h memw %0d exp 1111 100 0", o_be, o_ad, nw); end
    endtask

    task automatic test_byte_store;
        q.push_back('{4, 1'b0, last_rd});
        run_access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 3);
        e = q.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL bstore_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL bstore_result got %b %h exp %b %h", o_err, o_rd, e.err, e.rd); end
        checks++; if (o_be !== 4'b1000 || o_dout !== 32'hA5A5A5A5 || o_ad !== 32'h100) begin errors++; $display("FAIL bstore_bus got %b %h %h exp 1000 a5a5a5a5 100", o_be, o_dout, o_ad); end
        checks++; if (nw !== 4) begin errors++; $display("FAIL bstore_memw got %0d exp 4", nw); end
    endtask

    task automatic test_sign_ext;
        for (int s = 1; s >= 0; s--) begin
            q.push_back('{1, 1'b0, s ? 32'hFFFFFF80 : 32'h00000080});
            run_access(1'b0, 2'd0, s[0], 32'h102, 32'h0, 32'h00800000, 0);
            e = q.pop_front(); last_rd = e.rd;
            checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL sext%0d got lat %0d err %b rd %h exp %0d %b %h", s, lat, o_err, o_rd, e.lat, e.err, e.rd); end
            checks++; if (o_be !== 4'b0100) begin errors++; $display("FAIL sext%0d_be got %b exp 0100", s, o_be); end
        end
    endtask

    task automatic test_fault;
        q.push_back('{0, 1'b1, last_rd});
        run_access(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        e = q.pop_front();
        checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL misalign got lat %0d err %b rd %h exp %0d %b %h", lat, o_err, o_rd, e.lat, e.err, e.rd); end
        checks++; if (nc !== 0) begin errors++; $display("FAIL misalign_bus got %0d bus cycles exp 0", nc); end
        q.push_back('{0, 1'b1, last_rd});
        run_access(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        e = q.pop_front();
        checks++; if (lat !== e.lat || o_err !== e.err || nc !== 0) begin errors++; $display("FAIL dword got lat %0d err %b bus %0d exp %0d %b 0", lat, o_err, nc, e.lat, e.err); end
    endtask

    task automatic test_timeout;
        q.push_back('{16, 1'b1, last_rd});
        run_access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 99);
        e = q.pop_front();
        checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL timeout got lat %0d err %b rd %h exp %0d %b %h", lat, o_err, o_rd, e.lat, e.err, e.rd); end
        checks++; if (nc !== 16) begin errors++; $display("FAIL timeout_cycles got %0d exp 16", nc); end
        q.push_back('{16, 1'b0, 32'h12345678});
        run_access(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h12345678, 15);
        e = q.pop_front(); last_rd = e.rd;
        checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL tie got lat %0d err %b rd %h exp %0d %b %h", lat, o_err, o_rd, e.lat, e.err, e.rd); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h300; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (cpu_mio !== 1'b1 || mem_w !== 1'b1) begin errors++; $display("FAIL rmid_access got cpu_mio %b mem_w %b exp 1 1", cpu_mio, mem_w); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy, cpu_mio, mem_w, done} !== 4'b0) begin errors++; $display("FAIL rmid_idle got %b exp 0000", {busy, cpu_mio, mem_w, done}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h exp 0", rdata); end
        last_rd = '0;
        repeat (4) begin
            mio_ready = 1'b1;
            @(posedge clk); #1;
            pulses += int'(done);
        end
        mio_ready = 1'b0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_done got %0d pulses exp 0", pulses); end
    endtask

    task automatic test_after_reset;
        q.push_back('{3, 1'b0, 32'hFFFF8001});
        run_access(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 32'h80017777, 2);
        e = q.pop_front(); last_rd = e.rd;
        checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL post_reset got lat %0d err %b rd %h exp %0d %b %h", lat, o_err, o_rd, e.lat, e.err, e.rd); end
        checks++; if (o_be !== 4'b1100 || o_ad !== 32'h400) begin errors++; $display("FAIL post_reset_bus got %b %h exp 1100 400", o_be, o_ad); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 16; n++) begin
            logic [1:0] sz = 2'($urandom_range(0, 2));
            logic we = 1'($urandom);
            logic sg = 1'($urandom);
            logic [31:0] a = ($urandom & 32'hFFF0) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            logic [31:0] wd = $urandom, din = $urandom;
            int w = $urandom_range(0, 3);
            q.push_back('{w + 1, 1'b0, we ? last_rd : m_load(sz, sg, a, din)});
            run_access(we, sz, sg, a, wd, din, w);
            e = q.pop_front(); last_rd = e.rd;
            checks++; if (lat !== e.lat || o_err !== e.err || o_rd !== e.rd) begin errors++; $display("FAIL rnd%0d got lat %0d err %b rd %h exp %0d %b %h", n, lat, o_err, o_rd, e.lat, e.err, e.rd); end
            checks++; if (o_be !== m_be(sz, a) || o_ad !== {a[31:2], 2'b00} || (we && o_dout !== m_dout(sz, wd))) begin errors++; $display("FAIL rnd%0d_bus got %b %h %h exp %b %h %h", n, o_be, o_ad, o_dout, m_be(sz, a), {a[31:2], 2'b00}, m_dout(sz, wd)); end
            checks++; if (nw !== (we ? w + 1 : 0)) begin errors++; $display("FAIL rnd%0d_memw got %0d exp %0d", n, nw, we ? w + 1 : 0); end
        end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_byte_store;
        test_sign_ext;
        test_fault;
        test_timeout;
        test_reset_mid;
        test_after_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
